// File: rtl/seq_adder_defs.sv
// Shared definitions for the sequential adder/subtractor: FSM state
// encodings and a constant-evaluable ceil(log2) helper.
package seq_adder_defs;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // ceil(log2(n)); returns 0 for n <= 1
  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int v = n - 1; v > 0; v = v >> 1) begin
      r = r + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/adder_slice.sv
// Combinational DIGIT-bit ripple adder. c_msb is the carry into the top
// bit, which the top level needs for two's-complement overflow.
module adder_slice #(
  parameter int DIGIT = 4
) (
  input  logic [DIGIT-1:0] x,
  input  logic [DIGIT-1:0] y,
  input  logic             ci,
  output logic [DIGIT-1:0] s,
  output logic             co,
  output logic             c_msb
);

  logic [DIGIT:0] c;

  // Ripple the carry through the slice one bit at a time
  always_comb begin
    c    = '0;
    s    = '0;
    c[0] = ci;
    for (int i = 0; i < DIGIT; i++) begin
      s[i]     = x[i] ^ y[i] ^ c[i];
      c[i + 1] = (x[i] & y[i]) | (c[i] & (x[i] ^ y[i]));
    end
  end

  assign co    = c[DIGIT];
  assign c_msb = c[DIGIT-1];

endmodule

// File: rtl/seq_adder_sub.sv
// Multi-cycle adder/subtractor: processes DIGIT bits per clock, LSB slice
// first, with a registered carry between slices.
//
// Handshake: start is sampled only when busy==0 (state IDLE or DONE); a
// sampled start captures a/b/cin/sub and the caller may change them freely
// afterwards. done is a one-cycle pulse meaning sum/cout/ovf are valid;
// they then stay stable until the next accepted start clears them.
module seq_adder_sub
  import seq_adder_defs::*;
#(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int STEPS = WIDTH / DIGIT;
  localparam int CNTW  = (clog2(STEPS) < 1) ? 1 : clog2(STEPS);

  generate
    if (WIDTH < 1 || DIGIT < 1 || DIGIT > WIDTH || (WIDTH % DIGIT) != 0) begin : g_bad_params
      $error("seq_adder_sub: WIDTH must be a positive multiple of DIGIT");
    end
  endgenerate

  state_t            state;
  state_t            state_next;
  logic [WIDTH-1:0]  op_a;
  logic [WIDTH-1:0]  op_b;
  logic              carry;
  logic [CNTW-1:0]   cnt;
  logic [WIDTH-1:0]  sum_r;
  logic              cout_r;
  logic              ovf_r;

  logic              accept;
  logic              last;
  logic [DIGIT-1:0]  x_slice;
  logic [DIGIT-1:0]  y_slice;
  logic [DIGIT-1:0]  s_slice;
  logic              co_slice;
  logic              cmsb_slice;

  assign accept = start && (state != RUN);
  assign last   = (cnt == CNTW'(STEPS - 1));

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state logic; DONE can chain straight into RUN when start is held
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = RUN;
      RUN:     if (last)  state_next = DONE;
      DONE:    state_next = start ? RUN : IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Select the operand slices addressed by the step counter
  always_comb begin
    x_slice = '0;
    y_slice = '0;
    for (int i = 0; i < STEPS; i++) begin
      if (cnt == CNTW'(i)) begin
        x_slice = op_a[i*DIGIT +: DIGIT];
        y_slice = op_b[i*DIGIT +: DIGIT];
      end
    end
  end

  adder_slice #(.DIGIT(DIGIT)) u_slice (
    .x     (x_slice),
    .y     (y_slice),
    .ci    (carry),
    .s     (s_slice),
    .co    (co_slice),
    .c_msb (cmsb_slice)
  );

  // Datapath: capture operands on accept, then write one sum slice per cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      op_a   <= '0;
      op_b   <= '0;
      carry  <= 1'b0;
      cnt    <= '0;
      sum_r  <= '0;
      cout_r <= 1'b0;
      ovf_r  <= 1'b0;
    end else if (accept) begin
      op_a   <= a;
      op_b   <= sub ? ~b : b;
      carry  <= sub ? 1'b1 : cin;
      cnt    <= '0;
      sum_r  <= '0;
      cout_r <= 1'b0;
      ovf_r  <= 1'b0;
    end else if (state == RUN) begin
      for (int i = 0; i < STEPS; i++) begin
        if (cnt == CNTW'(i)) sum_r[i*DIGIT +: DIGIT] <= s_slice;
      end
      carry <= co_slice;
      cnt   <= cnt + CNTW'(1);
      if (last) begin
        cout_r <= co_slice;
        ovf_r  <= co_slice ^ cmsb_slice;
      end
    end
  end

  assign busy = (state == RUN);
  assign done = (state == DONE);
  assign sum  = sum_r;
  assign cout = cout_r;
  assign ovf  = ovf_r;

endmodule
